// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
// Shared definitions for the data-memory responder:
//   - default size of the memory-mapped register window
//   - register offsets inside that window and CTRL bit positions
//   - a register-select enum plus the helper that decodes an offset into it
// Optional timer: compiled in only when DATA_MEM_TIMER_EN is defined.
package data_mem_responder_pkg;

  localparam int MMIO_SIZE_DEFAULT = 16;

  localparam int OFF_GPIO_OUT = 0;
  localparam int OFF_GPIO_IN  = 1;
  localparam int OFF_CTRL     = 2;
  localparam int OFF_RELOAD   = 3;
  localparam int OFF_COUNT    = 4;
  localparam int OFF_PRESCALE = 5;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_AUTO_BIT = 1;
  localparam int CTRL_EXP_BIT  = 7;

  // REG_RAM marks the plain RAM range; REG_NONE marks unused register slots.
  typedef enum logic [2:0] {
    REG_RAM,
    REG_GPIO_OUT,
    REG_GPIO_IN,
    REG_CTRL,
    REG_RELOAD,
    REG_COUNT,
    REG_PRESCALE,
    REG_NONE
  } mmio_reg_e;

  function automatic mmio_reg_e decode_offset(input int off);
    case (off)
      OFF_GPIO_OUT: return REG_GPIO_OUT;
      OFF_GPIO_IN:  return REG_GPIO_IN;
      OFF_CTRL:     return REG_CTRL;
      OFF_RELOAD:   return REG_RELOAD;
      OFF_COUNT:    return REG_COUNT;
      OFF_PRESCALE: return REG_PRESCALE;
      default:      return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Data-memory bus between the core (master) and the responder (slave).
//   mem_addr   : address from the core
//   mem_WE     : write enable, a write happens on the clock edge where it is high
//   mem_data_i : write data from the core
//   mem_data_o : registered read data back to the core
interface data_mem_responder_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_data_i;
  logic [DATA_WIDTH-1:0] mem_data_o;

  modport master (output mem_addr, output mem_WE, output mem_data_i, input mem_data_o);
  modport slave  (input mem_addr, input mem_WE, input mem_data_i, output mem_data_o);

endinterface

// File: rtl/data_mem_responder_timer.sv
// mmio_timer
// Prescaled down-counting timer behind the CTRL/RELOAD/COUNT/PRESCALE registers.
// Instantiated by data_mem_responder only when DATA_MEM_TIMER_EN is defined.
// Ports:
//   clk, arst : clock and asynchronous active-high reset
//   wr_en     : CPU write strobe (qualified by reg_sel)
//   reg_sel   : register addressed by the current bus cycle
//   wr_data   : CPU write data
//   rd_data   : combinational read value of the selected timer register
//   irq       : registered one-cycle pulse on each expiry
module mmio_timer
  import data_mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  wr_en,
  input  mmio_reg_e             reg_sel,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  logic                  en_q, en_d;
  logic                  auto_q, auto_d;
  logic                  exp_q, exp_d;
  logic                  irq_q, irq_d;
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                  tick;
  logic                  expire;

  assign tick   = en_q && (pcnt_q == prescale_q);
  assign expire = tick && (count_q == '0);

  always_comb begin
    en_d       = en_q;
    auto_d     = auto_q;
    exp_d      = exp_q;
    irq_d      = 1'b0;
    reload_d   = reload_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;

    if (en_q) begin
      pcnt_d = tick ? '0 : pcnt_q + ONE;
    end

    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          en_d   = wr_data[CTRL_EN_BIT];
          auto_d = wr_data[CTRL_AUTO_BIT];
          if (wr_data[CTRL_EXP_BIT]) begin
            exp_d = 1'b0;
          end
          // Only a 0->1 enable restarts the period; re-writing EN=1 leaves it running.
          if (wr_data[CTRL_EN_BIT] && !en_q) begin
            count_d = reload_q;
            pcnt_d  = '0;
          end
        end
        REG_RELOAD:   reload_d   = wr_data;
        REG_PRESCALE: prescale_d = wr_data;
        default: ;
      endcase
    end

    // Timer events come after the CPU write so expiry wins over an EXP clear
    // and the pulse still goes out when the CPU stops the timer in the same cycle.
    if (tick) begin
      if (expire) begin
        exp_d = 1'b1;
        irq_d = 1'b1;
        if (auto_q) begin
          count_d = reload_q;
        end else begin
          en_d = 1'b0;
        end
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      en_q       <= 1'b0;
      auto_q     <= 1'b0;
      exp_q      <= 1'b0;
      irq_q      <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
    end else begin
      en_q       <= en_d;
      auto_q     <= auto_d;
      exp_q      <= exp_d;
      irq_q      <= irq_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_EN_BIT]   = en_q;
        rd_data[CTRL_AUTO_BIT] = auto_q;
        rd_data[CTRL_EXP_BIT]  = exp_q;
      end
      REG_RELOAD:   rd_data = reload_q;
      REG_COUNT:    rd_data = count_q;
      REG_PRESCALE: rd_data = prescale_q;
      default:      rd_data = '0;
    endcase
  end

  assign irq = irq_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder end of the core's data-memory port. The low address range is
// on-chip RAM; the top MMIO_SIZE addresses are registers (GPIO, optional timer).
// Ports:
//   clk, arst : clock and asynchronous active-high reset
//   bus       : data-memory bus (slave side), registered read data, 1-cycle latency
//   gpio_in   : external inputs, synchronised with two flops
//   gpio_out  : registered external outputs
//   timer_irq : one-cycle pulse on each timer expiry (0 without the timer)
// Build option: define DATA_MEM_TIMER_EN to include the timer registers.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MMIO_SIZE  = MMIO_SIZE_DEFAULT
) (
  input  logic                   clk,
  input  logic                   arst,
  data_mem_responder_if.slave    bus,
  input  logic [DATA_WIDTH-1:0]  gpio_in,
  output logic [DATA_WIDTH-1:0]  gpio_out,
  output logic                   timer_irq
);

  localparam int                    RAM_DEPTH = 2**ADDR_WIDTH - MMIO_SIZE;
  localparam logic [ADDR_WIDTH-1:0] MMIO_BASE = ADDR_WIDTH'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  mmio_reg_e             reg_sel;
  logic [DATA_WIDTH-1:0] timer_rd;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] gpio_out_q, gpio_out_d;
  logic [DATA_WIDTH-1:0] sync1_q, sync2_q;

  always_comb begin
    if (bus.mem_addr >= MMIO_BASE) begin
      reg_sel = decode_offset(int'(bus.mem_addr - MMIO_BASE));
    end else begin
      reg_sel = REG_RAM;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.mem_WE && reg_sel == REG_RAM) begin
      ram[bus.mem_addr] <= bus.mem_data_i;
    end
  end

  // Read mux samples pre-edge state, which gives read-before-write for free.
  always_comb begin
    rdata_d = '0;
    case (reg_sel)
      REG_RAM:      rdata_d = ram[bus.mem_addr];
      REG_GPIO_OUT: rdata_d = gpio_out_q;
      REG_GPIO_IN:  rdata_d = sync2_q;
      default:      rdata_d = timer_rd;
    endcase
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (bus.mem_WE && reg_sel == REG_GPIO_OUT) begin
      gpio_out_d = bus.mem_data_i;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rdata_q    <= '0;
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      rdata_q    <= rdata_d;
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

`ifdef DATA_MEM_TIMER_EN
  mmio_timer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_timer (
    .clk     (clk),
    .arst    (arst),
    .wr_en   (bus.mem_WE),
    .reg_sel (reg_sel),
    .wr_data (bus.mem_data_i),
    .rd_data (timer_rd),
    .irq     (timer_irq)
  );
`else
  assign timer_rd  = '0;
  assign timer_irq = 1'b0;
`endif

  assign bus.mem_data_o = rdata_q;
  assign gpio_out       = gpio_out_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Self-checking bench for data_mem_responder. Expected read data is pushed
// into a scoreboard queue when a bus cycle is driven and popped when the
// registered read data appears one edge later.
module tb_data_mem_responder;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } sb_entry_t;

  logic       clk;
  logic       arst;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;

  int compared;
  int mismatched;
  sb_entry_t expQ[$];

  data_mem_responder_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  data_mem_responder dut (
    .clk       (clk),
    .arst      (arst),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // One bus cycle: drive at negedge, optionally queue the expected read data,
  // then pop and compare right after the capturing edge.
  task automatic applyStimulus(input logic [7:0] addr, input logic we, input logic [7:0] wdata,
                               input bit doCheck, input logic [31:0] expected, input string tag);
    sb_entry_t e;
    @(negedge clk);
    bus.mem_addr   = addr;
    bus.mem_WE     = we;
    bus.mem_data_i = wdata;
    if (doCheck) begin
      e.tag   = tag;
      e.value = expected;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.mem_WE = 1'b0;
    if (doCheck) begin
      if (expQ.size() == 0) begin
        checkOutput({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput(e.tag, {24'd0, bus.mem_data_o}, e.value);
      end
    end
  endtask

  task automatic writeReg(input logic [7:0] addr, input logic [7:0] wdata);
    applyStimulus(addr, 1'b1, wdata, 1'b0, 32'd0, "");
  endtask

  task automatic readReg(input logic [7:0] addr, input logic [7:0] expected, input string tag);
    applyStimulus(addr, 1'b0, 8'h00, 1'b1, {24'd0, expected}, tag);
  endtask

  initial begin
    int irqFirst;
    int irqCount;
    compared   = 0;
    mismatched = 0;

    arst           = 1'b1;
    gpio_in        = 8'h00;
    bus.mem_addr   = 8'h00;
    bus.mem_WE     = 1'b0;
    bus.mem_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_mem_data_o", {24'd0, bus.mem_data_o}, 32'd0);
    checkOutput("reset_gpio_out",   {24'd0, gpio_out},       32'd0);
    checkOutput("reset_timer_irq",  {31'd0, timer_irq},      32'd0);
    @(negedge clk);
    arst = 1'b0;

    // RAM write/read and read-before-write
    writeReg(8'h10, 8'hA5);
    readReg(8'h10, 8'hA5, "ram_read");
    applyStimulus(8'h10, 1'b1, 8'h5A, 1'b1, 32'h0000_00A5, "ram_rbw_old");
    readReg(8'h10, 8'h5A, "ram_read_new");
    writeReg(8'h00, 8'h11);
    writeReg(8'hEF, 8'hEE);
    readReg(8'h00, 8'h11, "ram_low_edge");
    readReg(8'hEF, 8'hEE, "ram_high_edge");

    // GPIO
    writeReg(8'hF0, 8'h3C);
    checkOutput("gpio_out_pin", {24'd0, gpio_out}, 32'h3C);
    readReg(8'hF0, 8'h3C, "gpio_out_read");
    gpio_in = 8'h81;
    readReg(8'hF1, 8'h00, "gpio_in_sync_1");
    readReg(8'hF1, 8'h00, "gpio_in_sync_2");
    readReg(8'hF1, 8'h81, "gpio_in_sync_3");

`ifdef DATA_MEM_TIMER_EN
    // One-shot: (3+1)*(1+1) = 8 cycles to the pulse
    writeReg(8'hF5, 8'h01);
    writeReg(8'hF3, 8'h03);
    writeReg(8'hF2, 8'h01);
    irqFirst = -1;
    irqCount = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (timer_irq) begin
        irqCount++;
        if (irqFirst < 0) irqFirst = i;
      end
    end
    checkOutput("oneshot_irq_delay", irqFirst, 32'd8);
    checkOutput("oneshot_irq_count", irqCount, 32'd1);
    readReg(8'hF2, 8'h80, "oneshot_ctrl");
    readReg(8'hF4, 8'h00, "oneshot_count");

    // Auto-reload: pulse every 3 cycles
    writeReg(8'hF5, 8'h00);
    writeReg(8'hF3, 8'h02);
    writeReg(8'hF2, 8'h03);
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("auto_irq_c%0d", i), {31'd0, timer_irq}, {31'd0, (i % 3) == 0});
    end
    writeReg(8'hF2, 8'h83);
    readReg(8'hF2, 8'h03, "auto_exp_cleared");
    writeReg(8'hF2, 8'h83);
    readReg(8'hF2, 8'h83, "auto_exp_clear_vs_expiry");
    writeReg(8'hF2, 8'h00);

    // Reset in the middle of a long count
    writeReg(8'hF5, 8'h09);
    writeReg(8'hF3, 8'd50);
    writeReg(8'hF2, 8'h01);
    readReg(8'hF4, 8'd50, "midrun_count");
    repeat (3) @(posedge clk);
    readReg(8'h10, 8'h5A, "pre_reset_ram");
    #2;
    arst = 1'b1;
    #1;
    checkOutput("arst_mem_data_o", {24'd0, bus.mem_data_o}, 32'd0);
    checkOutput("arst_gpio_out",   {24'd0, gpio_out},       32'd0);
    checkOutput("arst_timer_irq",  {31'd0, timer_irq},      32'd0);
    @(negedge clk);
    arst = 1'b0;
    readReg(8'hF2, 8'h00, "arst_ctrl");
    readReg(8'hF4, 8'h00, "arst_count");
    readReg(8'hF3, 8'h00, "arst_reload");
    readReg(8'h10, 8'h5A, "arst_ram_kept");
`else
    // Timer not built: its slots read 0 and the irq never fires
    writeReg(8'hF2, 8'h03);
    writeReg(8'hF3, 8'h02);
    writeReg(8'hF5, 8'h00);
    irqCount = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (timer_irq) irqCount++;
    end
    checkOutput("notimer_irq_count", irqCount, 32'd0);
    readReg(8'hF2, 8'h00, "notimer_ctrl");
    readReg(8'hF3, 8'h00, "notimer_reload");
    readReg(8'hF4, 8'h00, "notimer_count");
    readReg(8'hF5, 8'h00, "notimer_prescale");
    readReg(8'h10, 8'h5A, "pre_reset_ram");
    #2;
    arst = 1'b1;
    #1;
    checkOutput("arst_mem_data_o", {24'd0, bus.mem_data_o}, 32'd0);
    checkOutput("arst_gpio_out",   {24'd0, gpio_out},       32'd0);
    @(negedge clk);
    arst = 1'b0;
    readReg(8'h10, 8'h5A, "arst_ram_kept");
`endif

    // Read-only and unused slots ignore writes
    writeReg(8'hF4, 8'h77);
    readReg(8'hF4, 8'h00, "ro_count_write");
    writeReg(8'hF1, 8'h55);
    readReg(8'hF1, 8'h81, "ro_gpio_in_write");
    writeReg(8'hF8, 8'h55);
    readReg(8'hF8, 8'h00, "unused_f8");
    readReg(8'hFF, 8'h00, "unused_ff");
    checkOutput("final_gpio_out", {24'd0, gpio_out}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
